// File: rtl/dht11_emulator.sv
// DHT11 sensor emulator: answers a host start pulse on the single-wire bus
// with the DHT11 response preamble and a 40-bit humidity/temperature frame.
// Optional feature: define DHT_EMU_CRC_ERR_EN to add i_crc_corrupt, which
// flips bit 0 of the transmitted checksum when it is high at frame latch.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | bus released, waiting for the host to pull low
// HOST_LOW   | timing the host start pulse (saturating counter)
// RESP_DLY   | start accepted, frame latched, waiting before the response
// RESP_LOW   | driving the 80 us response low
// RESP_HIGH  | releasing for the 80 us response high
// BIT_LOW    | driving the 50 us low that precedes every data bit
// BIT_HIGH   | releasing for 26 us (bit 0) or 70 us (bit 1)
// END_LOW    | driving the 50 us trailing low after the last bit
module dht11_emulator #(
    parameter int unsigned CLK_HZ        = 50_000_000,
    parameter int unsigned MIN_START_US  = 18000,
    parameter int unsigned RESP_DELAY_US = 30
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_dht_in,
    input  logic [7:0] i_hum_int,
    input  logic [7:0] i_hum_float,
    input  logic [7:0] i_temp_int,
    input  logic [7:0] i_temp_float,
`ifdef DHT_EMU_CRC_ERR_EN
    input  logic       i_crc_corrupt,
`endif
    output logic       o_dht_oe,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error
);

    localparam logic [15:0] C_DIV_M1      = 16'(CLK_HZ / 1000000 - 1);
    localparam logic [15:0] C_MIN_START   = 16'(MIN_START_US);
    localparam logic [15:0] C_RESP_DLY_M1 = 16'(RESP_DELAY_US - 1);
    localparam logic [15:0] C_80_M1       = 16'd79;
    localparam logic [15:0] C_50_M1       = 16'd49;
    localparam logic [15:0] C_26_M1       = 16'd25;
    localparam logic [15:0] C_70_M1       = 16'd69;
    localparam logic [15:0] C_GUARD_US    = 16'd2;
    localparam logic [15:0] C_CNT_MAX     = 16'hFFFF;
    localparam logic [5:0]  C_LAST_BIT    = 6'd39;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_HOST_LOW  = 3'd1,
        S_RESP_DLY  = 3'd2,
        S_RESP_LOW  = 3'd3,
        S_RESP_HIGH = 3'd4,
        S_BIT_LOW   = 3'd5,
        S_BIT_HIGH  = 3'd6,
        S_END_LOW   = 3'd7
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_sync;
    logic [2:0]  r_drv_hist;
    logic [15:0] r_pre;
    logic [15:0] r_us_cnt;
    logic [39:0] r_frame;
    logic [5:0]  r_bit_idx;
    logic        r_dht_oe;
    logic        r_busy;
    logic        r_done;
    logic        r_error;

    logic        w_tick;
    logic        w_bus_low;
    logic        w_collide;
    logic        w_bit;
    logic [15:0] w_dur_m1;
    logic        w_tc;
    logic        w_latch;
    logic        w_done;
    logic        w_error;
    logic [7:0]  w_chk;
    logic [7:0]  w_chk_tx;
    logic        w_drive_nxt;
    logic        w_busy_nxt;

    // Two-flop synchronizer for the asynchronous bus level, plus a short
    // history of our own drive enable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync     <= 2'b11;
            r_drv_hist <= 3'b000;
        end else begin
            r_sync     <= {r_sync[0], i_dht_in};
            r_drv_hist <= {r_drv_hist[1:0], r_dht_oe};
        end
    end

    // A low that may still be our own drive travelling through the
    // synchronizer is not treated as host activity.
    assign w_bus_low = ~r_sync[1] & ~r_dht_oe & ~(|r_drv_hist);

    // Free-running down-counter prescaler producing the 1 us tick.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pre <= '0;
        end else if (r_pre == '0) begin
            r_pre <= C_DIV_M1;
        end else begin
            r_pre <= r_pre - 16'd1;
        end
    end

    assign w_tick = (r_pre == '0);

    assign w_chk = i_hum_int + i_hum_float + i_temp_int + i_temp_float;
`ifdef DHT_EMU_CRC_ERR_EN
    assign w_chk_tx = w_chk ^ {7'd0, i_crc_corrupt};
`else
    assign w_chk_tx = w_chk;
`endif

    assign w_bit     = r_frame[r_bit_idx];
    assign w_collide = w_bus_low && (r_us_cnt >= C_GUARD_US);

    // Duration (in us, minus one) of the current timed state.
    always_comb begin
        w_dur_m1 = C_CNT_MAX;
        case (r_state)
            S_RESP_DLY:  w_dur_m1 = C_RESP_DLY_M1;
            S_RESP_LOW:  w_dur_m1 = C_80_M1;
            S_RESP_HIGH: w_dur_m1 = C_80_M1;
            S_BIT_LOW:   w_dur_m1 = C_50_M1;
            S_BIT_HIGH:  w_dur_m1 = w_bit ? C_70_M1 : C_26_M1;
            S_END_LOW:   w_dur_m1 = C_50_M1;
            default:     w_dur_m1 = C_CNT_MAX;
        endcase
    end

    assign w_tc = w_tick && (r_us_cnt >= w_dur_m1);

    // Next-state logic and single-cycle event strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_done      = 1'b0;
        w_error     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_bus_low) w_state_nxt = S_HOST_LOW;
            end
            S_HOST_LOW: begin
                if (!w_bus_low) begin
                    if (r_us_cnt >= C_MIN_START) begin
                        w_state_nxt = S_RESP_DLY;
                        w_latch     = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_RESP_DLY: begin
                if (w_collide) begin
                    w_state_nxt = S_IDLE;
                    w_error     = 1'b1;
                end else if (w_tc) begin
                    w_state_nxt = S_RESP_LOW;
                end
            end
            S_RESP_LOW: begin
                if (w_tc) w_state_nxt = S_RESP_HIGH;
            end
            S_RESP_HIGH: begin
                if (w_collide) begin
                    w_state_nxt = S_IDLE;
                    w_error     = 1'b1;
                end else if (w_tc) begin
                    w_state_nxt = S_BIT_LOW;
                end
            end
            S_BIT_LOW: begin
                if (w_tc) w_state_nxt = S_BIT_HIGH;
            end
            S_BIT_HIGH: begin
                if (w_collide) begin
                    w_state_nxt = S_IDLE;
                    w_error     = 1'b1;
                end else if (w_tc) begin
                    w_state_nxt = (r_bit_idx == '0) ? S_END_LOW : S_BIT_LOW;
                end
            end
            S_END_LOW: begin
                if (w_tc) begin
                    w_state_nxt = S_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Per-state microsecond counter; restarts on every state change and
    // saturates so an arbitrarily long host low cannot wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_us_cnt <= '0;
        end else if ((w_state_nxt != r_state) || (r_state == S_IDLE)) begin
            r_us_cnt <= '0;
        end else if (w_tick && (r_us_cnt != C_CNT_MAX)) begin
            r_us_cnt <= r_us_cnt + 16'd1;
        end
    end

    // Frame capture at start acceptance and MSB-first bit pointer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame   <= '0;
            r_bit_idx <= '0;
        end else if (w_latch) begin
            r_frame   <= {i_hum_int, i_hum_float, i_temp_int, i_temp_float, w_chk_tx};
            r_bit_idx <= C_LAST_BIT;
        end else if ((r_state == S_BIT_HIGH) && (w_state_nxt == S_BIT_LOW)) begin
            r_bit_idx <= r_bit_idx - 6'd1;
        end
    end

    assign w_drive_nxt = (w_state_nxt == S_RESP_LOW) || (w_state_nxt == S_BIT_LOW) ||
                         (w_state_nxt == S_END_LOW);
    assign w_busy_nxt  = (w_state_nxt != S_IDLE) && (w_state_nxt != S_HOST_LOW);

    // Registered outputs so the bus enable and status lines are glitch-free.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dht_oe <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_dht_oe <= w_drive_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done;
            r_error  <= w_error;
        end
    end

    assign o_dht_oe = r_dht_oe;
    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_error  = r_error;

endmodule

// File: tb/tb_dht11_emulator.sv
// Testbench for dht11_emulator. Runs with a 2 MHz clock parameter (2 cycles
// per us) and a 200 us minimum start so frames stay short in cycles.
module tb_dht11_emulator;

    localparam int unsigned CLK_HZ   = 2_000_000;
    localparam int unsigned MIN_US   = 200;
    localparam int unsigned RESP_US  = 30;
    localparam int          CPU      = CLK_HZ / 1000000;

    logic       clk;
    logic       rst_n;
    logic       host_low;
    logic       coll_low;
    logic [7:0] hum_int, hum_float, temp_int, temp_float;
    logic       crc_corrupt;
    logic       dht_in;
    logic       dht_oe, busy, done, error;

    int n_vec;
    int n_miss;
    int done_cnt;
    int err_cnt;
    logic [39:0] q_exp[$];

    assign dht_in = ~(dht_oe | host_low | coll_low);

    dht11_emulator #(
        .CLK_HZ       (CLK_HZ),
        .MIN_START_US (MIN_US),
        .RESP_DELAY_US(RESP_US)
    ) u_dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_dht_in     (dht_in),
        .i_hum_int    (hum_int),
        .i_hum_float  (hum_float),
        .i_temp_int   (temp_int),
        .i_temp_float (temp_float),
`ifdef DHT_EMU_CRC_ERR_EN
        .i_crc_corrupt(crc_corrupt),
`endif
        .o_dht_oe     (dht_oe),
        .o_busy       (busy),
        .o_done       (done),
        .o_error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done)  done_cnt++;
        if (error) err_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(input int n, input int us);
        return (n >= CPU * us - 3) && (n <= CPU * us + 1);
    endfunction

    // sel 0 = dht_oe, 1 = busy; n = negedges until the level is seen.
    task automatic wait_sig(input int sel, input logic lvl, input int budget,
                            output int n, output bit ok);
        logic s;
        n  = 0;
        ok = 1'b0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            s = (sel == 0) ? dht_oe : busy;
            if (s == lvl) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic host_start(input int us);
        host_low = 1'b1;
        repeat (CPU * us) @(negedge clk);
        host_low = 1'b0;
    endtask

    task automatic rx_frame(input bit scramble);
        int n, tot, exp_us, d0, e0;
        bit ok, hi_bad, lo_bad, b;
        logic [39:0] exp_f, got;
        d0 = done_cnt;
        e0 = err_cnt;
        got = '0;
        hi_bad = 1'b0;
        lo_bad = 1'b0;
        wait_sig(1, 1'b1, 60, n, ok);
        chk("busy_rise", ok, 1'b1);
        exp_f = (q_exp.size() > 0) ? q_exp.pop_front() : 40'hX;
        if (!ok) return;
        if (scramble) begin
            hum_int = 8'hA5; hum_float = 8'h5A; temp_int = 8'h3C; temp_float = 8'hC3;
        end
        exp_us = RESP_US + 80 + 80 + 40 * 50 + 50;
        for (int i = 0; i < 40; i++) exp_us += exp_f[i] ? 70 : 26;
        wait_sig(0, 1'b1, 400, n, ok);
        chk("resp_dly_us", ok && in_rng(n, RESP_US), 1'b1);
        if (!ok) return;
        tot = n;
        wait_sig(0, 1'b0, 400, n, ok);
        chk("resp_low_us", ok && in_rng(n, 80), 1'b1);
        if (!ok) return;
        tot += n;
        wait_sig(0, 1'b1, 400, n, ok);
        chk("resp_high_us", ok && in_rng(n, 80), 1'b1);
        if (!ok) return;
        tot += n;
        for (int i = 0; i < 40; i++) begin
            wait_sig(0, 1'b0, 400, n, ok);
            if (!ok) begin
                chk("bit_low_timeout", ok, 1'b1);
                return;
            end
            tot += n;
            if (!in_rng(n, 50)) lo_bad = 1'b1;
            wait_sig(0, 1'b1, 400, n, ok);
            if (!ok) begin
                chk("bit_high_timeout", ok, 1'b1);
                return;
            end
            tot += n;
            b = (n > CPU * 48);
            if (!in_rng(n, b ? 70 : 26)) hi_bad = 1'b1;
            got = {got[38:0], b};
        end
        chk("bit_low_width", lo_bad, 1'b0);
        chk("bit_high_width", hi_bad, 1'b0);
        wait_sig(0, 1'b0, 400, n, ok);
        chk("end_low_us", ok && in_rng(n, 50), 1'b1);
        tot += n;
        chk("busy_fall", busy, 1'b0);
        chk("frame_data", got, exp_f);
        chk("frame_len", (tot >= CPU * exp_us - CPU * 90) && (tot <= CPU * exp_us + 4), 1'b1);
        repeat (3) @(negedge clk);
        chk("done_count", done_cnt - d0, 1);
        chk("error_count", err_cnt - e0, 0);
    endtask

    task automatic run_frame(input logic [7:0] a, b, c, d, input logic [39:0] exp_f,
                             input bit scramble);
        hum_int = a; hum_float = b; temp_int = c; temp_float = d;
        q_exp.push_back(exp_f);
        host_start(MIN_US + 20);
        rx_frame(scramble);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        int n, e0, d0;
        bit ok, seen_oe, seen_busy;
        n_vec = 0; n_miss = 0; done_cnt = 0; err_cnt = 0;
        rst_n = 1'b0; host_low = 1'b0; coll_low = 1'b0; crc_corrupt = 1'b0;
        hum_int = '0; hum_float = '0; temp_int = '0; temp_float = '0;
        repeat (3) @(negedge clk);
        chk("rst_oe", dht_oe, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        run_frame(8'h37, 8'h00, 8'h19, 8'h00, 40'h37_00_19_00_50, 1'b0);
        run_frame(8'hFF, 8'hFF, 8'hFF, 8'h02, 40'hFF_FF_FF_02_FF, 1'b1);

        // Start pulse shorter than the minimum is dropped silently.
        e0 = err_cnt;
        seen_oe = 1'b0;
        seen_busy = 1'b0;
        host_start(MIN_US / 2);
        repeat (2000) begin
            @(negedge clk);
            seen_oe   |= dht_oe;
            seen_busy |= busy;
        end
        chk("short_oe", seen_oe, 1'b0);
        chk("short_busy", seen_busy, 1'b0);
        chk("short_error", err_cnt - e0, 0);

        // Collision 20 us into BIT_HIGH of bit 5.
        hum_int = 8'h37; hum_float = 8'h00; temp_int = 8'h19; temp_float = 8'h00;
        e0 = err_cnt;
        d0 = done_cnt;
        host_start(MIN_US + 20);
        wait_sig(1, 1'b1, 60, n, ok);
        chk("coll_busy_rise", ok, 1'b1);
        wait_sig(0, 1'b1, 400, n, ok);
        wait_sig(0, 1'b0, 400, n, ok);
        for (int i = 0; i < 6; i++) begin
            wait_sig(0, 1'b1, 400, n, ok);
            wait_sig(0, 1'b0, 400, n, ok);
        end
        chk("coll_reach_bit5", ok, 1'b1);
        repeat (CPU * 20) @(negedge clk);
        coll_low = 1'b1;
        repeat (8) @(negedge clk);
        chk("coll_error", err_cnt - e0, 1);
        chk("coll_oe", dht_oe, 1'b0);
        chk("coll_busy", busy, 1'b0);
        coll_low = 1'b0;
        repeat (200) @(negedge clk);
        chk("coll_error_once", err_cnt - e0, 1);
        chk("coll_no_done", done_cnt - d0, 0);
        chk("coll_idle_busy", busy, 1'b0);
        run_frame(8'h37, 8'h00, 8'h19, 8'h00, 40'h37_00_19_00_50, 1'b0);

`ifdef DHT_EMU_CRC_ERR_EN
        crc_corrupt = 1'b1;
        run_frame(8'h37, 8'h00, 8'h19, 8'h00, 40'h37_00_19_00_51, 1'b0);
        crc_corrupt = 1'b0;
`endif

        // Reset in RESP_LOW releases the bus immediately.
        hum_int = 8'h12; hum_float = 8'h34; temp_int = 8'h56; temp_float = 8'h78;
        host_start(MIN_US + 20);
        wait_sig(1, 1'b1, 60, n, ok);
        wait_sig(0, 1'b1, 400, n, ok);
        chk("rl_reach", ok, 1'b1);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rl_oe", dht_oe, 1'b0);
        chk("rl_busy", busy, 1'b0);
        chk("rl_done", done, 1'b0);
        chk("rl_error", error, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        seen_oe = 1'b0;
        seen_busy = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            seen_oe   |= dht_oe;
            seen_busy |= busy;
        end
        chk("rl_after_oe", seen_oe, 1'b0);
        chk("rl_after_busy", seen_busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
